sprite_blitter: RTL and testbench

- Parametrised sprite/background pixel engine between game-logic control and the VGA frame-buffer writer.
- On a start pulse it scans a rectangular image from an external synchronous ROM (1-cycle read latency) and emits one pixel per cycle (X, Y, colour, plot strobe).
- Modes: sprite (selectable from N sprites, placed at x/y, clipped to screen, optional colour-key transparency) and full-screen background copy.
- Replaces fixed-16x16, free-running pixel counters with a start/busy/done handshake.

---
 rtl/sprite_blitter.sv | 214 +++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module  : sprite_blitter
// Brief   : Scans a sprite or full-screen background out of a synchronous ROM
//           and emits one qualified pixel per cycle to the frame-buffer writer.
// Rev     : 1.0
// ============================================================================
module sprite_blitter #(
   parameter int                 SPR_W     = 16,
   parameter int                 SPR_H     = 16,
   parameter int                 NUM_SPR   = 4,
   parameter int                 SCR_W     = 320,
   parameter int                 SCR_H     = 240,
   parameter int                 COLOR_W   = 12,
   parameter logic [COLOR_W-1:0] KEY_COLOR = 12'h000,
   parameter int                 XW        = 9,
   parameter int                 YW        = 8,
   parameter int                 AW        = 17,
   localparam int                SEL_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               mode,
   input  logic [SEL_W-1:0]   spr_sel,
   input  logic [XW-1:0]      x_init,
   input  logic [YW-1:0]      y_init,
   input  logic               transp_en,
   output logic [AW-1:0]      rom_addr,
   output logic               rom_bg,
   input  logic [COLOR_W-1:0] rom_q,
   output logic [XW-1:0]      X_out,
   output logic [YW-1:0]      Y_out,
   output logic [COLOR_W-1:0] color_out,
   output logic               plot,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int             SPR_SIZE     = SPR_W * SPR_H;
   localparam logic [XW-1:0]  SPR_LAST_COL = XW'(SPR_W - 1);
   localparam logic [XW-1:0]  BG_LAST_COL  = XW'(SCR_W - 1);
   localparam logic [YW-1:0]  SPR_LAST_ROW = YW'(SPR_H - 1);
   localparam logic [YW-1:0]  BG_LAST_ROW  = YW'(SCR_H - 1);
   localparam logic [AW-1:0]  SPR_STRIDE   = AW'(SPR_W);
   localparam logic [AW-1:0]  BG_STRIDE    = AW'(SCR_W);
   localparam logic [XW:0]    X_LIMIT      = (XW+1)'(SCR_W);
   localparam logic [YW:0]    Y_LIMIT      = (YW+1)'(SCR_H);

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [XW-1:0]        x_init_q, x_init_d;
   logic [YW-1:0]        y_init_q, y_init_d;
   logic                 transp_en_q, transp_en_d;
   logic [XW-1:0]        col_q, col_d;
   logic [YW-1:0]        row_q, row_d;
   logic [AW-1:0]        row_base_q, row_base_d;
   logic [AW-1:0]        rom_addr_q, rom_addr_d;
   logic                 rom_bg_q, rom_bg_d;
   logic                 drain_cnt_q, drain_cnt_d;
   logic                 p1_valid_q, p1_valid_d;
   logic [XW:0]          p1_x_q, p1_x_d;
   logic [YW:0]          p1_y_q, p1_y_d;
   logic [XW-1:0]        x_out_q, x_out_d;
   logic [YW-1:0]        y_out_q, y_out_d;
   logic [COLOR_W-1:0]   color_out_q, color_out_d;
   logic                 plot_q, plot_d;

   logic [XW-1:0]        last_col;
   logic [YW-1:0]        last_row;
   logic [AW-1:0]        stride;
   logic [AW-1:0]        start_base;
   logic                 clipped;
   logic                 keyed;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         mode_q      <= 1'b0;
         x_init_q    <= '0;
         y_init_q    <= '0;
         transp_en_q <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         row_base_q  <= '0;
         rom_addr_q  <= '0;
         rom_bg_q    <= 1'b0;
         drain_cnt_q <= 1'b0;
         p1_valid_q  <= 1'b0;
         p1_x_q      <= '0;
         p1_y_q      <= '0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         color_out_q <= '0;
         plot_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         x_init_q    <= x_init_d;
         y_init_q    <= y_init_d;
         transp_en_q <= transp_en_d;
         col_q       <= col_d;
         row_q       <= row_d;
         row_base_q  <= row_base_d;
         rom_addr_q  <= rom_addr_d;
         rom_bg_q    <= rom_bg_d;
         drain_cnt_q <= drain_cnt_d;
         p1_valid_q  <= p1_valid_d;
         p1_x_q      <= p1_x_d;
         p1_y_q      <= p1_y_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
         color_out_q <= color_out_d;
         plot_q      <= plot_d;
      end
   end

   // Scan control: raster counters plus a row-base accumulator that avoids a row*W multiply.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      x_init_d    = x_init_q;
      y_init_d    = y_init_q;
      transp_en_d = transp_en_q;
      col_d       = col_q;
      row_d       = row_q;
      row_base_d  = row_base_q;
      rom_addr_d  = rom_addr_q;
      rom_bg_d    = rom_bg_q;
      drain_cnt_d = drain_cnt_q;

      last_col   = mode_q ? BG_LAST_COL : SPR_LAST_COL;
      last_row   = mode_q ? BG_LAST_ROW : SPR_LAST_ROW;
      stride     = mode_q ? BG_STRIDE   : SPR_STRIDE;
      start_base = mode ? '0 : AW'(spr_sel) * AW'(SPR_SIZE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_RUN;
               mode_d      = mode;
               x_init_d    = x_init;
               y_init_d    = y_init;
               transp_en_d = transp_en;
               col_d       = '0;
               row_d       = '0;
               row_base_d  = start_base;
               rom_addr_d  = start_base;
               rom_bg_d    = mode;
            end
         end
         ST_RUN: begin
            if (col_q == last_col && row_q == last_row) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = 1'b0;
            end else begin
               if (col_q == last_col) begin
                  col_d      = '0;
                  row_d      = row_q + YW'(1);
                  row_base_d = row_base_q + stride;
               end else begin
                  col_d = col_q + XW'(1);
               end
               rom_addr_d = row_base_d + AW'(col_d);
            end
         end
         ST_DRAIN: begin
            drain_cnt_d = 1'b1;
            if (drain_cnt_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stage 1 carries coordinates alongside the ROM read; stage 2 meets rom_q and qualifies.
   always_comb begin
      p1_valid_d = (state_q == ST_RUN);
      p1_x_d     = mode_q ? {1'b0, col_q} : ({1'b0, x_init_q} + {1'b0, col_q});
      p1_y_d     = mode_q ? {1'b0, row_q} : ({1'b0, y_init_q} + {1'b0, row_q});

      clipped = !mode_q && ((p1_x_q >= X_LIMIT) || (p1_y_q >= Y_LIMIT));
      keyed   = !mode_q && transp_en_q && (rom_q == KEY_COLOR);

      plot_d      = p1_valid_q && !clipped && !keyed;
      x_out_d     = p1_valid_q ? p1_x_q[XW-1:0] : x_out_q;
      y_out_d     = p1_valid_q ? p1_y_q[YW-1:0] : y_out_q;
      color_out_d = p1_valid_q ? rom_q          : color_out_q;
   end

   assign rom_addr  = rom_addr_q;
   assign rom_bg    = rom_bg_q;
   assign X_out     = x_out_q;
   assign Y_out     = y_out_q;
   assign color_out = color_out_q;
   assign plot      = plot_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_blitter
// Brief   : Randomised bench for sprite_blitter against a pixel-index model.
// Rev     : 1.0
// ============================================================================
module tb_sprite_blitter;

   localparam int SPR_W = 16;
   localparam int SPR_H = 16;
   localparam int SCR_W = 320;
   localparam int SCR_H = 240;
   localparam int SPR_N = SPR_W * SPR_H;
   localparam int BG_N  = SCR_W * SCR_H;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [1:0]  spr_sel = '0;
   logic [8:0]  x_init = '0;
   logic [7:0]  y_init = '0;
   logic        transp_en = 1'b0;
   logic [16:0] rom_addr;
   logic        rom_bg;
   logic [11:0] rom_q = '0;
   logic [8:0]  X_out;
   logic [7:0]  Y_out;
   logic [11:0] color_out;
   logic        plot;
   logic        busy;
   logic        done;

   sprite_blitter dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .mode      (mode),
      .spr_sel   (spr_sel),
      .x_init    (x_init),
      .y_init    (y_init),
      .transp_en (transp_en),
      .rom_addr  (rom_addr),
      .rom_bg    (rom_bg),
      .rom_q     (rom_q),
      .X_out     (X_out),
      .Y_out     (Y_out),
      .color_out (color_out),
      .plot      (plot),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // ROM contents and synchronous read model
   logic [11:0] spr_rom [0:4*SPR_N-1];

   function automatic logic [11:0] bg_color(input int a);
      return 12'(a ^ (a >> 7));
   endfunction

   always @(posedge clk)
      rom_q <= rom_bg ? bg_color(int'(rom_addr)) : spr_rom[rom_addr[9:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Behavioural model: one job described by its parameters and start cycle
   bit   cmp_en = 1'b0;
   bit   m_active = 1'b0;
   int   t0 = 0;
   bit   m_mode;
   int   m_sel, m_x, m_y;
   bit   m_tr;

   int   plot_cnt, first_t, first_x, first_y, first_c, last_x, last_y, last_c, done_t, first_addr;
   bit   first_seen;

   function automatic void model_pixel(input int k, output int addr, output int x, output int y,
                                       output bit vis, output logic [11:0] c);
      int w, col, row;
      w    = m_mode ? SCR_W : SPR_W;
      col  = k % w;
      row  = k / w;
      addr = m_mode ? k : m_sel * SPR_N + k;
      c    = m_mode ? bg_color(addr) : spr_rom[addr];
      x    = m_mode ? col : m_x + col;
      y    = m_mode ? row : m_y + row;
      vis  = m_mode ? 1'b1 : (x < SCR_W && y < SCR_H && !(m_tr && c == 12'h000));
   endfunction

   int          tt, n, ea, ex, ey;
   bit          ev, e_busy, e_done, e_plot;
   logic [11:0] ec;

   always @(negedge clk) begin
      if (cmp_en) begin
         e_busy = 1'b0;
         e_done = 1'b0;
         e_plot = 1'b0;
         tt     = cyc - t0;
         if (m_active) begin
            n      = m_mode ? BG_N : SPR_N;
            e_busy = (tt >= 1 && tt <= n + 2);
            e_done = (tt == n + 3);
            if (tt >= 1 && tt <= n) begin
               model_pixel(tt - 1, ea, ex, ey, ev, ec);
               chk("rom_addr", 32'(rom_addr), 32'(ea));
               chk("rom_bg", 32'(rom_bg), 32'(m_mode));
               if (tt == 1) first_addr = int'(rom_addr);
            end
            if (tt >= 3 && tt <= n + 2) begin
               model_pixel(tt - 3, ea, ex, ey, ev, ec);
               e_plot = ev;
            end
         end
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         chk("plot", 32'(plot), 32'(e_plot));
         if (e_plot) begin
            chk("X_out", 32'(X_out), 32'(ex % 512));
            chk("Y_out", 32'(Y_out), 32'(ey % 256));
            chk("color_out", 32'(color_out), 32'(ec));
         end
         if (plot) begin
            plot_cnt++;
            if (!first_seen) begin
               first_seen = 1'b1;
               first_t = tt;
               first_x = int'(X_out);
               first_y = int'(Y_out);
               first_c = int'(color_out);
            end
            last_x = int'(X_out);
            last_y = int'(Y_out);
            last_c = int'(color_out);
         end
         if (done) done_t = tt;
         if (e_done) m_active = 1'b0;
      end
   end

   // Drives one start pulse; the model only adopts it when the DUT should be idle
   task automatic do_start(input bit md, input int sel, input int x, input int y, input bit tr);
      @(posedge clk); #1;
      mode      = md;
      spr_sel   = 2'(sel);
      x_init    = 9'(x);
      y_init    = 8'(y);
      transp_en = tr;
      start     = 1'b1;
      if (!m_active) begin
         m_active   = 1'b1;
         t0         = cyc;
         m_mode     = md;
         m_sel      = sel;
         m_x        = x;
         m_y        = y;
         m_tr       = tr;
         plot_cnt   = 0;
         first_seen = 1'b0;
         done_t     = -1;
         first_addr = -1;
      end
      @(posedge clk); #1;
      start     = 1'b0;
      mode      = 1'($urandom);
      spr_sel   = 2'($urandom);
      x_init    = 9'($urandom);
      y_init    = 8'($urandom);
      transp_en = 1'($urandom);
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      while (m_active && i < 80000) begin
         @(posedge clk); #1;
         i++;
      end
      chk("job_timeout", 32'(m_active), 32'd0);
      m_active = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_plot"}, 32'(plot), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
      chk({tag, "_rom_bg"}, 32'(rom_bg), 0);
      chk({tag, "_X_out"}, 32'(X_out), 0);
      chk({tag, "_Y_out"}, 32'(Y_out), 0);
      chk({tag, "_color_out"}, 32'(color_out), 0);
   endtask

   initial begin
      int zeros, j;
      // Sprites 0 and 2 hold colour == address; 1 and 3 are random
      for (int i = 0; i < 4 * SPR_N; i++) spr_rom[i] = 12'(i);
      for (int i = 0; i < SPR_N; i++) spr_rom[SPR_N + i] = 12'($urandom_range(1, 4095));
      for (int i = 0; i < SPR_N; i++)
         spr_rom[3*SPR_N + i] = ($urandom_range(0, 5) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      zeros = 0;
      while (zeros < 100) begin
         j = $urandom_range(0, SPR_N - 1);
         if (spr_rom[SPR_N + j] != 12'h000) begin
            spr_rom[SPR_N + j] = 12'h000;
            zeros++;
         end
      end

      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      resetn = 1'b1;
      cmp_en = 1'b1;

      // Sprite 0 at (10,20): done lands on the 260th cycle counting the start cycle as 1
      do_start(1'b0, 0, 10, 20, 1'b0);
      wait_done();
      chk("t1_plots", plot_cnt, 256);
      chk("t1_first_t", first_t, 3);
      chk("t1_first_x", first_x, 10);
      chk("t1_first_y", first_y, 20);
      chk("t1_first_c", first_c, 0);
      chk("t1_last_x", last_x, 25);
      chk("t1_last_y", last_y, 35);
      chk("t1_last_c", last_c, 255);
      chk("t1_done_t", done_t, 259);

      // Sprite 2 clipped at the bottom-right corner
      do_start(1'b0, 2, 310, 235, 1'b0);
      wait_done();
      chk("t2_first_addr", first_addr, 512);
      chk("t2_plots", plot_cnt, 50);
      chk("t2_done_t", done_t, 259);

      // Colour-key transparency on sprite 1 (100 key pixels)
      do_start(1'b0, 1, 0, 0, 1'b1);
      wait_done();
      chk("t3_plots_key", plot_cnt, 156);
      do_start(1'b0, 1, 0, 0, 1'b0);
      wait_done();
      chk("t3_plots_nokey", plot_cnt, 256);

      // Start during RUN and start coincident with done are both ignored
      do_start(1'b0, 0, 100, 50, 1'b0);
      repeat (40) @(posedge clk);
      do_start(1'b1, 2, 200, 10, 1'b0);
      do begin
         @(posedge clk); #1;
      end while (m_active && (cyc - t0) < 259);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      chk("t5_plots", plot_cnt, 256);
      chk("t5_first_x", first_x, 100);
      chk("t5_last_x", last_x, 115);
      chk("t5_busy_after_done", 32'(busy), 0);

      // Reset asserted while pixel 100 is on the outputs
      do_start(1'b0, 3, int'($urandom_range(0, 300)), int'($urandom_range(0, 220)), 1'b1);
      while ((cyc - t0) < 103) begin
         @(posedge clk); #1;
      end
      resetn = 1'b0;
      @(posedge clk); #1;
      m_active = 1'b0;
      resetn   = 1'b1;
      @(negedge clk);
      chk_all_zero("midreset");
      do_start(1'b0, 0, 40, 60, 1'b0);
      wait_done();
      chk("t6_plots", plot_cnt, 256);
      chk("t6_done_t", done_t, 259);

      // Randomised sprite jobs
      for (int r = 0; r < 4; r++) begin
         do_start(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 255)), 1'($urandom));
         wait_done();
      end

      // Full-screen background; transp_en must have no effect here
      do_start(1'b1, 0, 0, 0, 1'b1);
      wait_done();
      chk("t4_plots", plot_cnt, BG_N);
      chk("t4_first_addr", first_addr, 0);
      chk("t4_last_x", last_x, 319);
      chk("t4_last_y", last_y, 239);
      chk("t4_done_t", done_t, BG_N + 3);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
